// File: rtl/instr_encoder.sv
// instr_encoder: turns ALU requests into 32-bit MIPS R-type / I-type words.
// Accepted legal words are buffered in a 2-entry FIFO; an illegal request
// produces a one-cycle except pulse and is dropped.
// Optional feature macro: INSTR_ENCODER_STATS_EN adds the inst_count and
// except_count statistics outputs.
module instr_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  alu_op,
    input  logic        alu_src2,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        except
`ifdef INSTR_ENCODER_STATS_EN
    ,
    output logic [15:0] inst_count,
    output logic [7:0]  except_count
`endif
);

    // Returns {legal, word}. Any opcode/operand-source pair not listed is illegal.
    function automatic logic [32:0] encode(
        input logic [2:0]  op,
        input logic        src2,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm
    );
        logic [5:0]  code;
        logic        legal;
        logic [31:0] word;
        legal = 1'b1;
        code  = 6'h00;
        if (src2 == 1'b0) begin
            case (op)
                3'd2:    code = 6'h20;
                3'd3:    code = 6'h22;
                3'd4:    code = 6'h24;
                3'd5:    code = 6'h25;
                3'd6:    code = 6'h27;
                3'd7:    code = 6'h26;
                default: legal = 1'b0;
            endcase
            word = {6'h00, f_rs, f_rt, f_rd, 5'h00, code};
        end else begin
            case (op)
                3'd2:    code = 6'h08;
                3'd4:    code = 6'h0c;
                3'd5:    code = 6'h0d;
                3'd7:    code = 6'h0e;
                default: legal = 1'b0;
            endcase
            word = {code, f_rs, f_rt, f_imm};
        end
        return {legal, word};
    endfunction

    logic [1:0]  count_r;
    logic [31:0] head_r;
    logic [31:0] tail_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        except_r;

    logic [32:0] enc_s;
    logic        legal_s;
    logic [31:0] word_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic [1:0]  count_nxt_s;
    logic [31:0] head_nxt_s;
    logic [31:0] tail_nxt_s;

    assign enc_s    = encode(alu_op, alu_src2, rs, rt, rd, imm);
    assign legal_s  = enc_s[32];
    assign word_s   = enc_s[31:0];
    assign accept_s = in_valid & in_ready_r;
    assign push_s   = accept_s & legal_s;
    assign pop_s    = out_valid_r & out_ready;

    // FIFO next state: head is always the oldest word, tail the second one.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_nxt_s  = word_s;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_nxt_s  = word_s;
                end else if (push_s) begin
                    tail_nxt_s  = word_s;
                    count_nxt_s = 2'd2;
                end else if (pop_s) begin
                    count_nxt_s = 2'd0;
                end else begin
                    count_nxt_s = 2'd1;
                end
            end
            2'd2: begin
                // in_ready is low when full, so no push can coincide here.
                if (pop_s) begin
                    head_nxt_s  = tail_r;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd2;
                end
            end
            default: begin
                count_nxt_s = 2'd0;
            end
        endcase
    end

    // FIFO state and flags derived from next occupancy so outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r     <= 2'd0;
            head_r      <= 32'h0000_0000;
            tail_r      <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            except_r    <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            in_ready_r  <= (count_nxt_s < 2'd2);
            except_r    <= accept_s & ~legal_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign inst      = head_r;
    assign except    = except_r;

`ifdef INSTR_ENCODER_STATS_EN
    logic [15:0] inst_count_r;
    logic [7:0]  except_count_r;

    // Legal-accept counter wraps; illegal-accept counter saturates at 0xFF.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_count_r   <= 16'h0000;
            except_count_r <= 8'h00;
        end else begin
            if (push_s) begin
                inst_count_r <= inst_count_r + 16'h0001;
            end
            if (accept_s && !legal_s && (except_count_r != 8'hFF)) begin
                except_count_r <= except_count_r + 8'h01;
            end
        end
    end

    assign inst_count   = inst_count_r;
    assign except_count = except_count_r;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words/except
// tokens; a negedge monitor pops and compares whatever the DUT presents.
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic        alu_src2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        except;
`ifdef INSTR_ENCODER_STATS_EN
    logic [15:0] inst_count;
    logic [7:0]  except_count;
`endif

    instr_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_src2  (alu_src2),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .except    (except)
`ifdef INSTR_ENCODER_STATS_EN
        ,
        .inst_count   (inst_count),
        .except_count (except_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic [31:0] exp_q[$];
    int          exc_q[$];
    logic        hold_r = 1'b0;
    logic [31:0] held_r = 32'h0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: a word is consumed at the coming posedge when valid&ready now.
    always @(negedge clock) begin
        if (reset) begin
            hold_r = 1'b0;
        end else begin
            if (out_valid) begin
                if (hold_r) check("inst_stable", inst, held_r);
                if (out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_word", inst, 32'hDEAD_BEEF);
                    else check("word", inst, exp_q.pop_front());
                end
                hold_r = !out_ready;
                held_r = inst;
            end else begin
                hold_r = 1'b0;
            end
            if (except) begin
                if (exc_q.size() == 0) check("unexpected_except", 32'd1, 32'd0);
                else begin
                    void'(exc_q.pop_front());
                    check("except", {31'd0, except}, 32'd1);
                end
            end
        end
    end

    // Drive a request and hold it until accepted; expectation queued on accept.
    task automatic send(input logic [2:0] op, input logic s2, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [15:0] im,
                        input logic ill, input logic [31:0] exp_word);
        logic rdy;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        alu_op = op; alu_src2 = s2; rs = a; rt = b; rd = d; imm = im;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy = in_ready;
            @(posedge clock); #1;
            if (rdy) begin
                done = 1'b1;
                if (ill) exc_q.push_back(1);
                else exp_q.push_back(exp_word);
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int t0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 3'd0; alu_src2 = 1'b0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0;
        idle(2);
        reset = 1'b0;
        idle(1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_except",    {31'd0, except},    32'd0);
        check("rst_inst",      inst,               32'h0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Basic encodings, latency of one cycle after accept
        send(3'd2, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 32'h0022_1820);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        send(3'd2, 1'b1, 5'd4, 5'd5, 5'd9, 16'hFFFF, 1'b0, 32'h2085_FFFF);
        send(3'd7, 1'b0, 5'd0, 5'd0, 5'd31, 16'h0, 1'b0, 32'h0000_F826);
        send(3'd3, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 32'h0022_1822);
        send(3'd4, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 32'h0022_1824);
        send(3'd5, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 32'h0022_1825);
        send(3'd6, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 32'h0022_1827);
        send(3'd4, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 32'h3022_1234);
        send(3'd5, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 32'h3422_1234);
        send(3'd7, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 32'h3822_1234);
        idle(3);

        // Illegal requests: sub-immediate, alu_op 1, nor-immediate, alu_op 0
        send(3'd3, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1, 1'b1, 32'h0);
        send(3'd1, 1'b0, 5'd1, 5'd2, 5'd3, 16'h1, 1'b1, 32'h0);
        idle(3);
        check("illegal_no_valid", {31'd0, out_valid}, 32'd0);
`ifdef INSTR_ENCODER_STATS_EN
        check("except_count", {24'd0, except_count}, 32'd2);
        check("inst_count", {16'd0, inst_count}, 32'd10);
`endif
        send(3'd6, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1, 1'b1, 32'h0);
        send(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 16'h1, 1'b1, 32'h0);
        idle(3);

        // Backpressure: two fill the FIFO, third waits until out_ready returns
        out_ready = 1'b0;
        send(3'd2, 1'b0, 5'd7, 5'd8, 5'd9, 16'h0, 1'b0, 32'h00E8_4820);
        send(3'd5, 1'b1, 5'd7, 5'd8, 5'd9, 16'h00AA, 1'b0, 32'h34E8_00AA);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(3'd7, 1'b0, 5'd10, 5'd11, 5'd12, 16'h0, 1'b0, 32'h014B_6026);
            begin
                idle(3);
                check("still_full", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Illegal request while FIFO holds words must not disturb order
        out_ready = 1'b0;
        send(3'd2, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 32'h0021_0820);
        send(3'd3, 1'b1, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h0);
        send(3'd4, 1'b1, 5'd2, 5'd2, 5'd2, 16'h00FF, 1'b0, 32'h3042_00FF);
        idle(2);
        out_ready = 1'b1;
        idle(4);

        // Throughput at full: one in, one out per cycle
        out_ready = 1'b0;
        send(3'd2, 1'b0, 5'd3, 5'd3, 5'd3, 16'h0, 1'b0, 32'h0063_1820);
        send(3'd2, 1'b0, 5'd4, 5'd4, 5'd4, 16'h0, 1'b0, 32'h0084_2020);
        out_ready = 1'b1;
        t0 = cyc;
        send(3'd4, 1'b0, 5'd5, 5'd5, 5'd5, 16'h0, 1'b0, 32'h00A5_2824);
        send(3'd5, 1'b0, 5'd6, 5'd6, 5'd6, 16'h0, 1'b0, 32'h00C6_3025);
        send(3'd6, 1'b0, 5'd7, 5'd7, 5'd7, 16'h0, 1'b0, 32'h00E7_3827);
        send(3'd7, 1'b0, 5'd8, 5'd8, 5'd8, 16'h0, 1'b0, 32'h0108_4026);
        check("throughput_cycles", cyc - t0, 32'd5);
        idle(4);

        // Reset with two words buffered: both discarded
        out_ready = 1'b0;
        send(3'd2, 1'b0, 5'd9, 5'd9, 5'd9, 16'h0, 1'b0, 32'h0);
        send(3'd2, 1'b0, 5'd10, 5'd10, 5'd10, 16'h0, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        exc_q.delete();
        idle(2);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_reset_inst", inst, 32'h0);
        idle(4);
        check("post_reset_no_valid", {31'd0, out_valid}, 32'd0);
        check("queues_drained", exp_q.size() + exc_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock, rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have: in_valid  input  1  request present.
REQ-004 SHALL have: in_ready  output  1  request accepted when in_valid&in_ready at clock edge.
REQ-005 SHALL have: alu_op  input  3  2=add 3=sub 4=and 5=or 6=nor 7=xor.
REQ-006 SHALL have: alu_src2  input  1  0=register operand (R-type), 1=immediate (I-type).
REQ-007 SHALL have: rs, rt, rd  input  5 each  register fields.
REQ-008 SHALL have: imm  input  16  immediate.
REQ-009 SHALL have: out_valid  output  1  inst holds a word.
REQ-010 SHALL have: out_ready  input  1  consumer takes word when out_valid&out_ready.
REQ-011 SHALL have: inst  output  32  encoded MIPS instruction word.
REQ-012 SHALL have: except  output  1  one-cycle pulse for an unencodable request.

Function
REQ-013 R-type SHALL encode {6'h00, rs, rt, rd, 5'h00, funct}; funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27.
REQ-014 I-type SHALL encode {opcode, rs, rt, imm}; opcode add 0x08, and 0x0c, or 0x0d, xor 0x0e; rd ignored.
REQ-015 Illegal: alu_op 0 or 1 (either alu_src2); sub or nor with alu_src2=1.
REQ-016 Accepted illegal request SHALL NOT enqueue; except=1 in the cycle after acceptance only.
REQ-017 Legal accepted words SHALL enter a 2-entry FIFO; inst/out_valid driven from head register.
REQ-018 Latency: accept at edge N into empty FIFO -> out_valid=1 with word after edge N.
REQ-019 in_ready SHALL equal (occupancy<2), registered-derived; no combinational path from out_ready or in_valid.
REQ-020 Full (2 entries): in_ready=0; requests held by producer, none lost.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-022 Pop while 1 entry and no push -> out_valid=0 next cycle; inst value when out_valid=0 is don't-care.
REQ-023 Words SHALL emerge in acceptance order; inst stable while out_valid=1 and out_ready=0.
REQ-024 Illegal request accepted while FIFO holds words SHALL not disturb FIFO contents or order.

Reset
REQ-025 reset SHALL asynchronously clear FIFO occupancy, pointers, out_valid=0, except=0, inst=0, in_ready=1 after release.
REQ-026 Reset mid-transfer SHALL discard all buffered words; no word appears after release without a new request.
REQ-027 Statistics counters (if compiled) SHALL reset to 0.

Configuration
REQ-028 Macro INSTR_ENCODER_STATS_EN SHALL, when defined, add outputs inst_count (16, wrapping, +1 per legal accept) and except_count (8, saturating at 0xFF, +1 per illegal accept).
REQ-029 Without INSTR_ENCODER_STATS_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 add rs=1 rt=2 rd=3, alu_src2=0, out_ready=1 -> inst=0x00221820, out_valid one cycle after accept.
REQ-031 add alu_src2=1 rs=4 rt=5 imm=0xFFFF -> inst=0x2085FFFF; xor R-type rs=0 rt=0 rd=31 -> 0x0000F826.
REQ-032 out_ready=0, three legal requests back-to-back -> two accepted, in_ready=0 on third; release out_ready -> words in order, third then accepted.
REQ-033 sub with alu_src2=1, then alu_op=1 -> except pulses 1 cycle each, no out_valid; except_count=2 with STATS_EN.
REQ-034 reset asserted with 2 words buffered -> out_valid=0 immediately, in_ready=1 after release, no stale word emitted.
REQ-035 Full FIFO, out_ready=1 and in_valid=1 every cycle -> one word out and one in per cycle, occupancy constant.
